// File: rtl/enc_pkg.sv
// Shared widths and FSM state type for the request encoder slice.
package enc_pkg;
    localparam int REQ_W = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
endpackage

// File: rtl/prio_enc_8x3.sv
// Combinational priority encoder; direction chosen by i_low_first.
module prio_enc_8x3
    import enc_pkg::*;
(
    input  logic [REQ_W-1:0] i_vec,
    input  logic             i_low_first,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        if (i_low_first) begin
            // Scan downward so the lowest set bit is written last and wins.
            for (int i = REQ_W - 1; i >= 0; i--) begin
                if (i_vec[i]) o_idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < REQ_W; i++) begin
                if (i_vec[i]) o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/req_encoder_8x3.sv
// Pending-request register with a non-preemptive grant/hold handshake.
//   state | meaning
//   IDLE  | no grant outstanding; grant the top pending request if any
//   HOLD  | idx_out/valid_out frozen until the consumer takes the grant
module req_encoder_8x3
    import enc_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REQ_W-1:0] req_in,
    input  logic             ready_in,
    output logic [IDX_W-1:0] idx_out,
    output logic             valid_out,
    output logic [REQ_W-1:0] pending_out,
    output logic             coalesce_out
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [REQ_W-1:0] r_pending;
    logic [IDX_W-1:0] r_idx;
    logic             r_valid;
    logic             r_coal;

    logic [IDX_W-1:0] w_enc_idx;
    logic             w_enc_any;
    logic             w_hs;
    logic             w_load;
    logic [REQ_W-1:0] w_clr;

    prio_enc_8x3 u_prio (
        .i_vec       (r_pending),
        .i_low_first (LOW_FIRST),
        .o_idx       (w_enc_idx),
        .o_any       (w_enc_any)
    );

    assign w_hs  = r_valid & ready_in;
    assign w_clr = w_hs ? (REQ_W'(1) << r_idx) : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_enc_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (ready_in) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // A new request on the bit being cleared survives: set is ORed in last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_coal    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | req_in;
            r_coal    <= |(req_in & r_pending);
            if (w_load) begin
                r_idx   <= w_enc_idx;
                r_valid <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign idx_out      = r_idx;
    assign valid_out    = r_valid;
    assign pending_out  = r_pending;
    assign coalesce_out = r_coal;

endmodule

// File: tb/tb_req_encoder_8x3.sv
// Directed bench: two encoder instances (low-first and high-first) share stimulus;
// expected grant indices are queued at stimulus time and popped on each handshake.
module tb_req_encoder_8x3;

    logic       clk;
    logic       rst;
    logic [7:0] req_in;
    logic       ready_in;

    logic [2:0] idx_lo, idx_hi;
    logic       valid_lo, valid_hi;
    logic [7:0] pend_lo, pend_hi;
    logic       coal_lo, coal_hi;

    int errors = 0;
    int checks = 0;
    int q_lo[$];
    int q_hi[$];
    logic prev_valid;

    req_encoder_8x3 #(.LOW_FIRST(1'b1)) dut_lo (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .ready_in     (ready_in),
        .idx_out      (idx_lo),
        .valid_out    (valid_lo),
        .pending_out  (pend_lo),
        .coalesce_out (coal_lo)
    );

    req_encoder_8x3 #(.LOW_FIRST(1'b0)) dut_hi (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .ready_in     (ready_in),
        .idx_out      (idx_hi),
        .valid_out    (valid_hi),
        .pending_out  (pend_hi),
        .coalesce_out (coal_hi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops expected grants for any handshake about to happen at the coming edge,
    // then advances one cycle and returns at the falling edge.
    task automatic step();
        int exp_idx;
        if (valid_lo && ready_in) begin
            checks++;
            assert (q_lo.size() != 0)
            else begin
                errors++;
                $error("FAIL lo_unexpected_grant: observed idx=%0d expected no grant", idx_lo);
            end
            if (q_lo.size() != 0) begin
                exp_idx = q_lo.pop_front();
                check("lo_grant_idx", 32'(idx_lo), 32'(exp_idx));
            end
        end
        if (valid_hi && ready_in) begin
            checks++;
            assert (q_hi.size() != 0)
            else begin
                errors++;
                $error("FAIL hi_unexpected_grant: observed idx=%0d expected no grant", idx_hi);
            end
            if (q_hi.size() != 0) begin
                exp_idx = q_hi.pop_front();
                check("hi_grant_idx", 32'(idx_hi), 32'(exp_idx));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        check("lo_queue_drained", 32'(q_lo.size()), 32'd0);
        check("hi_queue_drained", 32'(q_hi.size()), 32'd0);
        q_lo.delete();
        q_hi.delete();
        req_in   = 8'h00;
        ready_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        req_in   = 8'h00;
        ready_in = 1'b0;
        @(negedge clk);
        check("rst_idx",   32'(idx_lo),   32'd0);
        check("rst_valid", 32'(valid_lo), 32'd0);
        check("rst_pend",  32'(pend_lo),  32'd0);
        check("rst_coal",  32'(coal_lo),  32'd0);
        rst = 1'b0;

        // Single request, consumer always ready.
        ready_in = 1'b1;
        req_in   = 8'h20;
        q_lo.push_back(5);
        q_hi.push_back(5);
        step();
        req_in = 8'h00;
        check("single_pend_set", 32'(pend_lo), 32'h20);
        check("single_valid_early", 32'(valid_lo), 32'd0);
        step();
        check("single_valid", 32'(valid_lo), 32'd1);
        check("single_idx", 32'(idx_lo), 32'd5);
        step();
        check("single_pend_clr", 32'(pend_lo), 32'h00);
        check("single_valid_drop", 32'(valid_lo), 32'd0);
        step();
        check("single_no_regrant", 32'(valid_lo), 32'd0);

        // Three requests at once: priority order in both directions, spaced grants.
        do_reset();
        ready_in = 1'b1;
        req_in   = 8'h91;
        q_lo.push_back(0); q_lo.push_back(4); q_lo.push_back(7);
        q_hi.push_back(7); q_hi.push_back(4); q_hi.push_back(0);
        step();
        req_in     = 8'h00;
        prev_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            check("order_no_back_to_back", 32'(valid_lo & prev_valid), 32'd0);
            prev_valid = valid_lo;
            step();
        end
        check("order_pend_empty", 32'(pend_lo), 32'h00);

        // Hold without preemption.
        do_reset();
        req_in = 8'h08;
        step();
        req_in = 8'h00;
        step();
        check("hold_valid", 32'(valid_lo), 32'd1);
        check("hold_idx", 32'(idx_lo), 32'd3);
        req_in = 8'h01;
        step();
        req_in = 8'h00;
        for (int c = 0; c < 3; c++) begin
            check("hold_stable_idx", 32'(idx_lo), 32'd3);
            check("hold_stable_valid", 32'(valid_lo), 32'd1);
            step();
        end
        check("hold_pend_both", 32'(pend_lo), 32'h09);
        q_lo.push_back(3); q_lo.push_back(0);
        q_hi.push_back(3); q_hi.push_back(0);
        ready_in = 1'b1;
        for (int c = 0; c < 5; c++) step();

        // Ready while idle does nothing; handshake with same-bit re-request.
        do_reset();
        ready_in = 1'b1;
        step();
        check("idle_ready_valid", 32'(valid_lo), 32'd0);
        check("idle_ready_pend", 32'(pend_lo), 32'h00);
        ready_in = 1'b0;
        req_in   = 8'h04;
        step();
        req_in = 8'h00;
        step();
        check("regrant_first_idx", 32'(idx_lo), 32'd2);
        q_lo.push_back(2); q_lo.push_back(2);
        q_hi.push_back(2); q_hi.push_back(2);
        ready_in = 1'b1;
        req_in   = 8'h04;
        step();
        req_in = 8'h00;
        check("set_wins_pend", 32'(pend_lo[2]), 32'd1);
        check("set_wins_valid_drop", 32'(valid_lo), 32'd0);
        step();
        check("regrant_valid", 32'(valid_lo), 32'd1);
        check("regrant_idx", 32'(idx_lo), 32'd2);
        step();
        check("regrant_pend_clr", 32'(pend_lo), 32'h00);

        // Coalesce pulse.
        do_reset();
        req_in = 8'h08;
        step();
        check("coal_first", 32'(coal_lo), 32'd0);
        step();
        check("coal_pulse", 32'(coal_lo), 32'd1);
        req_in = 8'h00;
        step();
        check("coal_drop", 32'(coal_lo), 32'd0);
        check("coal_pend", 32'(pend_lo), 32'h08);
        q_lo.push_back(3);
        q_hi.push_back(3);
        ready_in = 1'b1;
        for (int c = 0; c < 3; c++) step();

        // Asynchronous reset in HOLD with everything pending.
        do_reset();
        req_in = 8'hFF;
        step();
        req_in = 8'h00;
        step();
        check("pre_rst_valid", 32'(valid_lo), 32'd1);
        check("pre_rst_pend", 32'(pend_lo), 32'hFF);
        #2;
        rst    = 1'b1;
        req_in = 8'hFF;
        #1;
        check("async_valid", 32'(valid_lo), 32'd0);
        check("async_idx", 32'(idx_lo), 32'd0);
        check("async_pend", 32'(pend_lo), 32'h00);
        check("async_hi_pend", 32'(pend_hi), 32'h00);
        @(negedge clk);
        check("rst_ignores_req", 32'(pend_lo), 32'h00);
        rst    = 1'b0;
        req_in = 8'h00;
        for (int c = 0; c < 4; c++) begin
            step();
            check("post_rst_no_grant", 32'(valid_lo), 32'd0);
        end
        check("post_rst_pend", 32'(pend_lo), 32'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/req_encoder_8x3.md
REQ_ENCODER_8X3 -- requirements
Module: req_encoder_8x3

Interface
REQ-001 Parameter LOW_FIRST, default 1: 1 = bit 0 highest priority; 0 = bit 7 highest priority.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_in  input  8  request bits; each high bit is captured each cycle (pulse or level).
REQ-006 ready_in  input  1  consumer accepts idx_out when ready_in and valid_out are both high.
REQ-007 idx_out  output  3  binary index of the granted request, registered.
REQ-008 valid_out  output  1  idx_out holds a valid grant, registered.
REQ-009 pending_out  output  8  current pending-request register.
REQ-010 coalesce_out  output  1  one-cycle pulse: some req_in bit was high while that bit was already pending.

Function
REQ-011 Pending update: pending <= (pending & ~clr) | req_in.
- clr = onehot(idx_out) on a handshake cycle, else 0.
- Set SHALL win over clear on the same bit in the same cycle.
REQ-012 coalesce_out SHALL be registered: (req_in & pending) != 0, evaluated before the update.
REQ-013 Two-state FSM, IDLE and HOLD; reset state IDLE.
REQ-014 In IDLE with pending != 0, the block SHALL:
- load idx_out with the priority-encoded index of pending;
- set valid_out = 1;
- go to HOLD.
REQ-015 In IDLE with pending == 0: valid_out stays 0 and idx_out holds its last value.
REQ-016 In HOLD with ready_in = 0: idx_out and valid_out SHALL stay stable, even if a higher-priority request arrives (no preemption).
REQ-017 In HOLD with ready_in = 1: clear the granted bit per REQ-011, drive valid_out = 0 next cycle, return to IDLE.
- There are therefore at least 2 cycles between consecutive grants.
REQ-018 Latency: req_in high at edge N -> pending bit set after N -> valid_out high after edge N+1, when IDLE and no higher-priority bit is pending.
REQ-019 ready_in while valid_out = 0 SHALL have no effect.
REQ-020 If all 8 bits are pending, grants SHALL follow strict priority order; lower-priority bits may starve while higher ones re-request.
REQ-021 Index arithmetic is 3-bit unsigned; onehot(idx) = 8'b1 << idx. No out-of-range values are possible.

Reset
REQ-022 On rst high, the block SHALL immediately force, independent of clk:
- state = IDLE;
- pending = 0, idx_out = 0, valid_out = 0, coalesce_out = 0.
REQ-023 Reset asserted mid-HOLD SHALL drop the grant and all pending requests; no handshake is implied.
REQ-024 req_in sampled while rst is high SHALL be ignored. Capture resumes on the first rising edge after rst deasserts.

Structure
REQ-025 Shared package enc_pkg SHALL hold:
- REQ_W = 8 and IDX_W = 3;
- the FSM state type with IDLE and HOLD.
REQ-026 Priority encoding SHALL be a purely combinational sub-module prio_enc_8x3:
- inputs: 8-bit vector and LOW_FIRST;
- outputs: 3-bit index and any-flag.
REQ-027 Everything else (pending register, FSM, output registers) SHALL live in req_encoder_8x3 and be clocked by clk with asynchronous reset by rst.

Verification
REQ-028 Reset, then req_in = 8'h20 for one cycle with ready_in = 1 -> valid_out = 1 and idx_out = 5 two edges later; pending_out = 8'h00 after the handshake.
REQ-029 LOW_FIRST = 1, req_in = 8'h91 for one cycle, ready_in held at 1 -> grant sequence 0, 4, 7, each valid for one cycle with one idle cycle between; with LOW_FIRST = 0 -> 7, 4, 0.
REQ-030 Grant idx_out = 3 held with ready_in = 0, then req_in = 8'h01 -> idx_out stays 3 until ready_in = 1; the next grant is 0.
REQ-031 Handshake on idx 2 in the same cycle as req_in = 8'h04 -> pending_out[2] remains 1 and idx 2 is granted again.
REQ-032 pending = 8'h08 and req_in = 8'h08 -> coalesce_out pulses for exactly one cycle.
REQ-033 Assert rst asynchronously mid-HOLD with pending = 8'hFF -> all outputs 0 before the next clk edge; no grant after release until a new req_in.
